// File: rtl/bcd_entry_reg.sv
// bcd_entry_reg
// Keypad digit-entry register for the calculator datapath. Decimal digits are
// shifted in at the least-significant position; backspace, clear and sign
// toggle edit the entry. Empty positions always hold the blank code 4'hA.
// An optional multi-cycle BCD-to-binary converter feeds the ALU.
//
// Optional feature macro: BCD_ENTRY_BIN_EN
//   defined   : conversion FSM, accumulator and value register are built
//   undefined : value/busy/done tied low, convert ignored, edits never blocked
//
// Parameters
//   DIGITS        number of BCD positions (1..8)
//   BIN_W         binary magnitude width, 2^BIN_W > 10^DIGITS - 1
// Ports
//   clock_i       rising-edge clock
//   reset_i       synchronous active-high reset
//   digit_i       digit to enter (0..9 legal)
//   load_i        enter digit_i at position 0
//   bksp_i        remove the most recently entered digit
//   clear_i       blank all positions, clear sign (aborts a conversion)
//   neg_toggle_i  invert the sign
//   convert_i     start a BCD-to-binary conversion
//   bcd_o         packed digits, position 0 at [3:0]
//   count_o       number of digits entered
//   negative_o    current sign
//   overflow_o    one-cycle pulse when a load is rejected because the entry is full
//   busy_o        conversion walk in progress
//   done_o        one-cycle pulse when value_o has just been updated
//   value_o       binary magnitude of the last completed conversion

module bcd_entry_reg #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic [3:0]                 digit_i,
    input  logic                       load_i,
    input  logic                       bksp_i,
    input  logic                       clear_i,
    input  logic                       neg_toggle_i,
    input  logic                       convert_i,
    output logic [4*DIGITS-1:0]        bcd_o,
    output logic [$clog2(DIGITS+1)-1:0] count_o,
    output logic                       negative_o,
    output logic                       overflow_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [BIN_W-1:0]           value_o
);

    localparam int         CW    = $clog2(DIGITS + 1);
    localparam logic [3:0] BLANK = 4'hA;

    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [CW-1:0]       count_q, count_d;
    logic                neg_q, neg_d;
    logic                ovf_q, ovf_d;
    logic                editBlocked;

    // Entry editing. Clear always wins; the remaining edits are mutually
    // exclusive by priority and are frozen while the converter walks the digits.
    always_comb begin
        bcd_d   = bcd_q;
        count_d = count_q;
        neg_d   = neg_q;
        ovf_d   = 1'b0;
        if (clear_i) begin
            bcd_d   = {DIGITS{BLANK}};
            count_d = '0;
            neg_d   = 1'b0;
        end else if (!editBlocked) begin
            if (bksp_i) begin
                if (count_q != '0) begin
                    for (int i = 0; i < DIGITS - 1; i++) begin
                        bcd_d[4*i +: 4] = bcd_q[4*(i+1) +: 4];
                    end
                    bcd_d[4*(DIGITS-1) +: 4] = BLANK;
                    count_d = count_q - CW'(1);
                end
            end else if (load_i) begin
                // A full entry only reports overflow for a legal digit; an
                // illegal digit is dropped silently either way.
                if (count_q == CW'(DIGITS)) begin
                    ovf_d = (digit_i <= 4'd9);
                end else if (digit_i <= 4'd9) begin
                    for (int i = 1; i < DIGITS; i++) begin
                        bcd_d[4*i +: 4] = bcd_q[4*(i-1) +: 4];
                    end
                    bcd_d[3:0] = digit_i;
                    count_d    = count_q + CW'(1);
                end
            end else if (neg_toggle_i) begin
                neg_d = ~neg_q;
            end
        end
    end

    // Entry state registers.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            bcd_q   <= {DIGITS{BLANK}};
            count_q <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            bcd_q   <= bcd_d;
            count_q <= count_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bcd_o      = bcd_q;
    assign count_o    = count_q;
    assign negative_o = neg_q;
    assign overflow_o = ovf_q;

`ifdef BCD_ENTRY_BIN_EN
    // ARM is a one-cycle gap between sampling convert and the digit walk, so
    // busy spans exactly DIGITS cycles and done lands DIGITS+1 edges after
    // the convert edge. Only clear is honoured while arming.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam int         IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [BIN_W-1:0] acc_q, acc_d;
    logic [BIN_W-1:0] value_q, value_d;
    logic             done_q, done_d;
    logic [3:0]       curDigit;
    logic [3:0]       digitVal;
    logic [BIN_W-1:0] stepSum;

    assign editBlocked = (state_q == S_RUN);

    // Select the digit under the walk index; blanks contribute zero.
    // acc*10 is built from shifts and cannot overflow for a legal BIN_W.
    always_comb begin
        curDigit = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                curDigit = bcd_q[4*i +: 4];
            end
        end
        digitVal = (curDigit > 4'd9) ? 4'd0 : curDigit;
        stepSum  = (acc_q << 3) + (acc_q << 1) + BIN_W'(digitVal);
    end

    // Conversion FSM: walk from the most significant position down to 0,
    // then publish the result. Clear abandons the walk and keeps value.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        value_d = value_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (convert_i) begin
                    state_d = S_ARM;
                    acc_d   = '0;
                    idx_d   = IW'(DIGITS - 1);
                end
            end
            S_ARM: begin
                state_d = clear_i ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (clear_i) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = stepSum;
                    if (idx_q == '0) begin
                        value_d = stepSum;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q - IW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Conversion state registers.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            value_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            value_q <= value_d;
            done_q  <= done_d;
        end
    end

    assign busy_o  = (state_q == S_RUN);
    assign done_o  = done_q;
    assign value_o = value_q;
`else
    logic unused_convert;

    assign unused_convert = convert_i;
    assign editBlocked    = 1'b0;
    assign busy_o         = 1'b0;
    assign done_o         = 1'b0;
    assign value_o        = '0;
`endif

endmodule

// File: tb/tb_bcd_entry_reg.sv
// tb_bcd_entry_reg
// Directed bench for bcd_entry_reg. Instance dutA uses the default 3-digit
// configuration, dutB uses DIGITS=5 / BIN_W=17. Each step pushes the expected
// output snapshot onto a scoreboard queue, drives one clock of stimulus, and
// pops/compares the snapshot 1 time unit after the edge. Conversion steps are
// only present when BCD_ENTRY_BIN_EN is defined.

module tb_bcd_entry_reg;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic [3:0]  digitA, digitB;
    logic        loadA, bkspA, clearA, negA_in, convA;
    logic        loadB, bkspB, clearB, negB_in, convB;

    logic [11:0] bcdA;
    logic [1:0]  countA;
    logic        negA, ovfA, busyA, doneA;
    logic [9:0]  valueA;

    logic [19:0] bcdB;
    logic [2:0]  countB;
    logic        negB, ovfB, busyB, doneB;
    logic [16:0] valueB;

    bcd_entry_reg dutA (
        .clock_i      (clock),
        .reset_i      (reset),
        .digit_i      (digitA),
        .load_i       (loadA),
        .bksp_i       (bkspA),
        .clear_i      (clearA),
        .neg_toggle_i (negA_in),
        .convert_i    (convA),
        .bcd_o        (bcdA),
        .count_o      (countA),
        .negative_o   (negA),
        .overflow_o   (ovfA),
        .busy_o       (busyA),
        .done_o       (doneA),
        .value_o      (valueA)
    );

    bcd_entry_reg #(.DIGITS(5), .BIN_W(17)) dutB (
        .clock_i      (clock),
        .reset_i      (reset),
        .digit_i      (digitB),
        .load_i       (loadB),
        .bksp_i       (bkspB),
        .clear_i      (clearB),
        .neg_toggle_i (negB_in),
        .convert_i    (convB),
        .bcd_o        (bcdB),
        .count_o      (countB),
        .negative_o   (negB),
        .overflow_o   (ovfB),
        .busy_o       (busyB),
        .done_o       (doneB),
        .value_o      (valueB)
    );

    typedef struct {
        int          which;
        string       tag;
        logic [31:0] bcd;
        logic [3:0]  cnt;
        logic        neg;
        logic        ovf;
        logic        busy;
        logic        done;
        logic [31:0] value;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Drive one cycle of stimulus on the chosen instance, then release it.
    task automatic applyStimulus(input int which, input int rst, input int d,
                                 input int ld, input int bk, input int cl,
                                 input int ng, input int cv);
        reset = rst[0];
        if (which == 0) begin
            digitA = d[3:0]; loadA = ld[0]; bkspA = bk[0];
            clearA = cl[0]; negA_in = ng[0]; convA = cv[0];
        end else begin
            digitB = d[3:0]; loadB = ld[0]; bkspB = bk[0];
            clearB = cl[0]; negB_in = ng[0]; convB = cv[0];
        end
        @(posedge clock);
        #1;
        reset  = 1'b0;
        digitA = 4'h0; loadA = 1'b0; bkspA = 1'b0; clearA = 1'b0; negA_in = 1'b0; convA = 1'b0;
        digitB = 4'h0; loadB = 1'b0; bkspB = 1'b0; clearB = 1'b0; negB_in = 1'b0; convB = 1'b0;
    endtask

    // Pop the oldest expected snapshot and compare it with the instance outputs.
    task automatic checkOutput();
        exp_t        e;
        logic [71:0] obs;
        logic [71:0] expv;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard: queue empty when output was due");
            return;
        end
        e = sb.pop_front();
        if (e.which == 0)
            obs = {20'h0, bcdA, 2'b0, countA, negA, ovfA, busyA, doneA, 22'h0, valueA};
        else
            obs = {12'h0, bcdB, 1'b0, countB, negB, ovfB, busyB, doneB, 15'h0, valueB};
        expv = {e.bcd, e.cnt, e.neg, e.ovf, e.busy, e.done, e.value};
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s: observed bcd=%h cnt=%0d neg=%b ovf=%b busy=%b done=%b value=%0d, expected bcd=%h cnt=%0d neg=%b ovf=%b busy=%b done=%b value=%0d",
                   e.tag, obs[71:40], obs[39:36], obs[35], obs[34], obs[33], obs[32], obs[31:0],
                   e.bcd, e.cnt, e.neg, e.ovf, e.busy, e.done, e.value);
        end
    endtask

    // One directed step: record the expectation, clock the stimulus, compare.
    task automatic step(input int which, input string tag, input int rst, input int d,
                        input int ld, input int bk, input int cl, input int ng, input int cv,
                        input int eBcd, input int eCnt, input int eNeg, input int eOvf,
                        input int eBusy, input int eDone, input int eVal);
        exp_t e;
        e.which = which;
        e.tag   = tag;
        e.bcd   = eBcd;
        e.cnt   = eCnt[3:0];
        e.neg   = eNeg[0];
        e.ovf   = eOvf[0];
        e.busy  = eBusy[0];
        e.done  = eDone[0];
        e.value = eVal;
        sb.push_back(e);
        applyStimulus(which, rst, d, ld, bk, cl, ng, cv);
        checkOutput();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Arguments: which, tag, rst, digit, load, bksp, clear, neg, convert,
    //            expected bcd, count, negative, overflow, busy, done, value
    initial begin
        reset  = 1'b1;
        digitA = 4'h0; loadA = 1'b0; bkspA = 1'b0; clearA = 1'b0; negA_in = 1'b0; convA = 1'b0;
        digitB = 4'h0; loadB = 1'b0; bkspB = 1'b0; clearB = 1'b0; negB_in = 1'b0; convB = 1'b0;
        $display("[TB] starting bcd_entry_reg directed sequence");

        step(0, "reset",          1, 0, 0, 0, 0, 0, 0, 'hAAA, 0, 0, 0, 0, 0, 0);
        step(0, "load1",          0, 1, 1, 0, 0, 0, 0, 'hAA1, 1, 0, 0, 0, 0, 0);
        step(0, "load2",          0, 2, 1, 0, 0, 0, 0, 'hA12, 2, 0, 0, 0, 0, 0);
        step(0, "load3",          0, 3, 1, 0, 0, 0, 0, 'h123, 3, 0, 0, 0, 0, 0);
        step(0, "load_full",      0, 7, 1, 0, 0, 0, 0, 'h123, 3, 0, 1, 0, 0, 0);
        step(0, "ovf_one_cycle",  0, 0, 0, 0, 0, 0, 0, 'h123, 3, 0, 0, 0, 0, 0);
        step(0, "bksp1",          0, 0, 0, 1, 0, 0, 0, 'hA12, 2, 0, 0, 0, 0, 0);
        step(0, "bksp2",          0, 0, 0, 1, 0, 0, 0, 'hAA1, 1, 0, 0, 0, 0, 0);
        step(0, "bksp3",          0, 0, 0, 1, 0, 0, 0, 'hAAA, 0, 0, 0, 0, 0, 0);
        step(0, "bksp_empty",     0, 0, 0, 1, 0, 0, 0, 'hAAA, 0, 0, 0, 0, 0, 0);
        step(0, "neg_at_empty",   0, 0, 0, 0, 0, 1, 0, 'hAAA, 0, 1, 0, 0, 0, 0);
        step(0, "bksp_keeps_neg", 0, 0, 0, 1, 0, 0, 0, 'hAAA, 0, 1, 0, 0, 0, 0);
        step(0, "bksp_over_load0",0, 5, 1, 1, 0, 0, 0, 'hAAA, 0, 1, 0, 0, 0, 0);
        step(0, "load5",          0, 5, 1, 0, 0, 0, 0, 'hAA5, 1, 1, 0, 0, 0, 0);
        step(0, "bksp_over_load", 0, 5, 1, 1, 0, 0, 0, 'hAAA, 0, 1, 0, 0, 0, 0);
        step(0, "load4",          0, 4, 1, 0, 0, 0, 0, 'hAA4, 1, 1, 0, 0, 0, 0);
        step(0, "clear_over_load",0, 2, 1, 0, 1, 0, 0, 'hAAA, 0, 0, 0, 0, 0, 0);
        step(0, "load_illegal",   0,11, 1, 0, 0, 0, 0, 'hAAA, 0, 0, 0, 0, 0, 0);
        step(0, "load0",          0, 0, 1, 0, 0, 0, 0, 'hAA0, 1, 0, 0, 0, 0, 0);
        step(0, "load_over_neg",  0, 9, 1, 0, 0, 1, 0, 'hA09, 2, 0, 0, 0, 0, 0);
        step(0, "neg_toggle",     0, 0, 0, 0, 0, 1, 0, 'hA09, 2, 1, 0, 0, 0, 0);
        step(0, "clear",          0, 0, 0, 0, 1, 0, 0, 'hAAA, 0, 0, 0, 0, 0, 0);

`ifdef BCD_ENTRY_BIN_EN
        step(0, "load4b",         0, 4, 1, 0, 0, 0, 0, 'hAA4, 1, 0, 0, 0, 0, 0);
        step(0, "load2b",         0, 2, 1, 0, 0, 0, 0, 'hA42, 2, 0, 0, 0, 0, 0);
        step(0, "cv42_arm",       0, 0, 0, 0, 0, 0, 1, 'hA42, 2, 0, 0, 0, 0, 0);
        step(0, "cv42_busy1",     0, 0, 0, 0, 0, 0, 0, 'hA42, 2, 0, 0, 1, 0, 0);
        step(0, "cv42_load_ign",  0, 7, 1, 0, 0, 0, 0, 'hA42, 2, 0, 0, 1, 0, 0);
        step(0, "cv42_busy3",     0, 0, 0, 0, 0, 0, 0, 'hA42, 2, 0, 0, 1, 0, 0);
        step(0, "cv42_done",      0, 0, 0, 0, 0, 0, 0, 'hA42, 2, 0, 0, 0, 1, 42);
        step(0, "cv42_hold",      0, 0, 0, 0, 0, 0, 0, 'hA42, 2, 0, 0, 0, 0, 42);
        step(0, "clear2",         0, 0, 0, 0, 1, 0, 0, 'hAAA, 0, 0, 0, 0, 0, 42);
        step(0, "load9a",         0, 9, 1, 0, 0, 0, 0, 'hAA9, 1, 0, 0, 0, 0, 42);
        step(0, "load9b",         0, 9, 1, 0, 0, 0, 0, 'hA99, 2, 0, 0, 0, 0, 42);
        step(0, "load9c",         0, 9, 1, 0, 0, 0, 0, 'h999, 3, 0, 0, 0, 0, 42);
        step(0, "cv999_arm",      0, 0, 0, 0, 0, 0, 1, 'h999, 3, 0, 0, 0, 0, 42);
        step(0, "cv999_busy1",    0, 0, 0, 0, 0, 0, 0, 'h999, 3, 0, 0, 1, 0, 42);
        step(0, "cv999_busy2",    0, 0, 0, 0, 0, 0, 0, 'h999, 3, 0, 0, 1, 0, 42);
        step(0, "cv999_busy3",    0, 0, 0, 0, 0, 0, 0, 'h999, 3, 0, 0, 1, 0, 42);
        step(0, "cv999_done",     0, 0, 0, 0, 0, 0, 0, 'h999, 3, 0, 0, 0, 1, 999);
        step(0, "cv999_pulse",    0, 0, 0, 0, 0, 0, 0, 'h999, 3, 0, 0, 0, 0, 999);
        step(0, "clear3",         0, 0, 0, 0, 1, 0, 0, 'hAAA, 0, 0, 0, 0, 0, 999);
        step(0, "load1b",         0, 1, 1, 0, 0, 0, 0, 'hAA1, 1, 0, 0, 0, 0, 999);
        step(0, "cv_with_load",   0, 2, 1, 0, 0, 0, 1, 'hA12, 2, 0, 0, 0, 0, 999);
        step(0, "cv12_busy1",     0, 0, 0, 0, 0, 0, 0, 'hA12, 2, 0, 0, 1, 0, 999);
        step(0, "cv12_busy2",     0, 0, 0, 0, 0, 0, 0, 'hA12, 2, 0, 0, 1, 0, 999);
        step(0, "cv12_busy3",     0, 0, 0, 0, 0, 0, 0, 'hA12, 2, 0, 0, 1, 0, 999);
        step(0, "cv12_done",      0, 0, 0, 0, 0, 0, 0, 'hA12, 2, 0, 0, 0, 1, 12);
        step(0, "abort_arm",      0, 0, 0, 0, 0, 0, 1, 'hA12, 2, 0, 0, 0, 0, 12);
        step(0, "abort_busy",     0, 0, 0, 0, 0, 0, 0, 'hA12, 2, 0, 0, 1, 0, 12);
        step(0, "abort_clear",    0, 0, 0, 0, 1, 0, 0, 'hAAA, 0, 0, 0, 0, 0, 12);
        step(0, "abort_no_done1", 0, 0, 0, 0, 0, 0, 0, 'hAAA, 0, 0, 0, 0, 0, 12);
        step(0, "abort_no_done2", 0, 0, 0, 0, 0, 0, 0, 'hAAA, 0, 0, 0, 0, 0, 12);
        step(0, "neg_pre_reset",  0, 0, 0, 0, 0, 1, 0, 'hAAA, 0, 1, 0, 0, 0, 12);
        step(0, "load3b",         0, 3, 1, 0, 0, 0, 0, 'hAA3, 1, 1, 0, 0, 0, 12);
        step(0, "rst_cv_arm",     0, 0, 0, 0, 0, 0, 1, 'hAA3, 1, 1, 0, 0, 0, 12);
        step(0, "rst_cv_busy",    0, 0, 0, 0, 0, 0, 0, 'hAA3, 1, 1, 0, 1, 0, 12);
        step(0, "reset_mid_cv",   1, 0, 0, 0, 0, 0, 0, 'hAAA, 0, 0, 0, 0, 0, 0);
        step(0, "after_reset",    0, 0, 0, 0, 0, 0, 0, 'hAAA, 0, 0, 0, 0, 0, 0);
`else
        step(0, "cv_off_load",    0, 4, 1, 0, 0, 0, 1, 'hAA4, 1, 0, 0, 0, 0, 0);
        step(0, "cv_off_idle1",   0, 0, 0, 0, 0, 0, 0, 'hAA4, 1, 0, 0, 0, 0, 0);
        step(0, "cv_off_load2",   0, 2, 1, 0, 0, 0, 1, 'hA42, 2, 0, 0, 0, 0, 0);
        step(0, "cv_off_idle2",   0, 0, 0, 0, 0, 0, 0, 'hA42, 2, 0, 0, 0, 0, 0);
        step(0, "cv_off_idle3",   0, 0, 0, 0, 0, 0, 0, 'hA42, 2, 0, 0, 0, 0, 0);
        step(0, "cv_off_idle4",   0, 0, 0, 0, 0, 0, 0, 'hA42, 2, 0, 0, 0, 0, 0);
`endif

        step(1, "b_neg",          0, 0, 0, 0, 0, 1, 0, 'hAAAAA, 0, 1, 0, 0, 0, 0);
        step(1, "b_load6",        0, 6, 1, 0, 0, 0, 0, 'hAAAA6, 1, 1, 0, 0, 0, 0);
        step(1, "b_load5",        0, 5, 1, 0, 0, 0, 0, 'hAAA65, 2, 1, 0, 0, 0, 0);
        step(1, "b_load5b",       0, 5, 1, 0, 0, 0, 0, 'hAA655, 3, 1, 0, 0, 0, 0);
        step(1, "b_load3",        0, 3, 1, 0, 0, 0, 0, 'hA6553, 4, 1, 0, 0, 0, 0);
        step(1, "b_load5c",       0, 5, 1, 0, 0, 0, 0, 'h65535, 5, 1, 0, 0, 0, 0);
        step(1, "b_load_full",    0, 1, 1, 0, 0, 0, 0, 'h65535, 5, 1, 1, 0, 0, 0);

`ifdef BCD_ENTRY_BIN_EN
        step(1, "b_cv_arm",       0, 0, 0, 0, 0, 0, 1, 'h65535, 5, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, "b_cv_busy",  0, 0, 0, 0, 0, 0, 0, 'h65535, 5, 1, 0, 1, 0, 0);
        end
        step(1, "b_cv_done",      0, 0, 0, 0, 0, 0, 0, 'h65535, 5, 1, 0, 0, 1, 65535);
        step(1, "b_cv_hold",      0, 0, 0, 0, 0, 0, 0, 'h65535, 5, 1, 0, 0, 0, 65535);
`else
        step(1, "b_cv_off",       0, 0, 0, 0, 0, 0, 1, 'h65535, 5, 1, 0, 0, 0, 0);
        step(1, "b_cv_off_idle",  0, 0, 0, 0, 0, 0, 0, 'h65535, 5, 1, 0, 0, 0, 0);
`endif

        step(1, "b_bksp",         0, 0, 0, 1, 0, 0, 0, 'hA6553, 4, 1, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
